// File: rtl/ar_prefetch_arbiter_pkg.sv
// Shared types and widths for the AR prefetch arbiter.
// Contents: arbiter state enum, AR request payload struct, throttle reload helper.
package ar_prefetch_arbiter_pkg;

  localparam int unsigned ADDR_BITS         = 16;
  localparam int unsigned BURST_LEN_WIDTH   = 8;
  localparam int unsigned TID_WIDTH         = 8;
  localparam int unsigned LOG_QUEUE_SIZE    = 3;
  localparam int unsigned OUTS_W            = LOG_QUEUE_SIZE + 1;
  localparam int unsigned PRFETCH_FRQ_WIDTH = 6;
  localparam int unsigned AGE_LIMIT         = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_DM    = 2'd1,
    ST_PF    = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_BITS-1:0]       addr;
    logic [BURST_LEN_WIDTH-1:0] len;
    logic [TID_WIDTH-1:0]       id;
  } ar_req_t;

  // The grant cycle itself counts as the first cycle of the gap, so the
  // counter is loaded one short; throttle 0 and 1 both allow back-to-back.
  function automatic logic [PRFETCH_FRQ_WIDTH-1:0] thr_reload(
    input logic [PRFETCH_FRQ_WIDTH-1:0] throttle
  );
    if (throttle == '0) return '0;
    return throttle - PRFETCH_FRQ_WIDTH'(1);
  endfunction

endpackage

// File: rtl/ar_prefetch_arbiter_if.sv
// AR channel bundle (valid/ready + request payload).
// master: drives valid/req, receives ready. slave: receives valid/req, drives ready.
interface ar_prefetch_arbiter_if;
  import ar_prefetch_arbiter_pkg::*;

  logic    valid;
  logic    ready;
  ar_req_t req;

  modport master (output valid, output req, input ready);
  modport slave  (input valid, input req, output ready);

endinterface

// File: rtl/ar_prefetch_arbiter_pf_rate_limiter.sv
// Prefetch bandwidth throttle: after a grant, blocks further prefetch grants
// until the programmed number of cycles has elapsed.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   i_load       prefetch grant this cycle
//   i_throttle   min cycles between prefetch grants
//   o_ready      registered: throttle counter is zero
module ar_prefetch_arbiter_pf_rate_limiter
  import ar_prefetch_arbiter_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_load,
  input  logic [PRFETCH_FRQ_WIDTH-1:0] i_throttle,
  output logic                         o_ready
);

  logic [PRFETCH_FRQ_WIDTH-1:0] r_cnt;
  logic [PRFETCH_FRQ_WIDTH-1:0] w_cnt_next;
  logic                         r_ready;

  // Load on grant, otherwise count down and saturate at zero.
  always_comb begin
    w_cnt_next = r_cnt;
    if (i_load) begin
      w_cnt_next = thr_reload(i_throttle);
    end else if (r_cnt != '0) begin
      w_cnt_next = r_cnt - PRFETCH_FRQ_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_ready <= 1'b1;
    end else begin
      r_cnt   <= w_cnt_next;
      r_ready <= (w_cnt_next == '0);
    end
  end

  assign o_ready = r_ready;

endmodule

// File: rtl/ar_prefetch_arbiter.sv
// Shares one DDR AR port between demand and prefetch reads. Demand has strict
// priority; prefetch is gated by an outstanding-burst limit and a bandwidth
// throttle. A one-entry registered slot drives the DDR AR channel.
// Optional feature macro: ARB_AGING_EN (lets a starved prefetch win once over demand).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   en                       0 blocks prefetch grants
//   dm_ar  (slave)           demand AR source
//   pf_ar  (slave)           prefetch AR source
//   m_ar   (master)          DDR AR sink
//   m_ar_is_pf               slot holds a prefetch request
//   pf_done                  one prefetch burst fully returned
//   crs_prOutstandingLimit   max in-flight prefetch bursts (0 = prefetch off)
//   crs_prBandwidthThrottle  min cycles between prefetch grants
//   pf_outstanding           in-flight prefetch count
//   err_underflow            sticky: pf_done seen with zero outstanding
module ar_prefetch_arbiter
  import ar_prefetch_arbiter_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  ar_prefetch_arbiter_if.slave         dm_ar,
  ar_prefetch_arbiter_if.slave         pf_ar,
  ar_prefetch_arbiter_if.master        m_ar,
  output logic                         m_ar_is_pf,
  input  logic                         pf_done,
  input  logic [OUTS_W-1:0]            crs_prOutstandingLimit,
  input  logic [PRFETCH_FRQ_WIDTH-1:0] crs_prBandwidthThrottle,
  output logic [OUTS_W-1:0]            pf_outstanding,
  output logic                         err_underflow
);

  arb_state_t          r_state;
  logic                r_valid;
  logic                r_is_pf;
  ar_req_t             r_req;
  logic [OUTS_W-1:0]   r_out;
  logic                r_err;

  logic w_free;
  logic w_thr_ready;
  logic w_pf_elig;
  logic w_force_pf;
  logic w_dm_ready;
  logic w_pf_ready;
  logic w_gnt_dm;
  logic w_gnt_pf;
  logic w_done_ok;

  // Slot can take a new request when empty or when its current one leaves now.
  assign w_free     = (r_state == ST_EMPTY) | (r_valid & m_ar.ready);
  assign w_pf_elig  = en & (r_out < crs_prOutstandingLimit) & w_thr_ready;
  assign w_dm_ready = w_free & ~w_force_pf;
  assign w_pf_ready = w_free & w_pf_elig & (~dm_ar.valid | w_force_pf);
  assign w_gnt_dm   = dm_ar.valid & w_dm_ready;
  assign w_gnt_pf   = pf_ar.valid & w_pf_ready;
  assign w_done_ok  = pf_done & (r_out != '0);

  assign dm_ar.ready    = w_dm_ready;
  assign pf_ar.ready    = w_pf_ready;
  assign m_ar.valid     = r_valid;
  assign m_ar.req       = r_req;
  assign m_ar_is_pf     = r_is_pf;
  assign pf_outstanding = r_out;
  assign err_underflow  = r_err;

  ar_prefetch_arbiter_pf_rate_limiter u_rate_limiter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_gnt_pf),
    .i_throttle (crs_prBandwidthThrottle),
    .o_ready    (w_thr_ready)
  );

`ifdef ARB_AGING_EN
  localparam int unsigned AGE_W = $clog2(AGE_LIMIT + 1);

  logic [AGE_W-1:0] r_age;

  // Counts cycles an eligible prefetch loses to demand; saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_age <= '0;
    end else if (w_gnt_pf) begin
      r_age <= '0;
    end else if (pf_ar.valid & w_pf_elig & dm_ar.valid & w_free &
                 (r_age != AGE_W'(AGE_LIMIT))) begin
      r_age <= r_age + AGE_W'(1);
    end
  end

  assign w_force_pf = (r_age >= AGE_W'(AGE_LIMIT)) & pf_ar.valid & w_pf_elig;
`else
  assign w_force_pf = 1'b0;
`endif

  // Slot FSM; payload holds while the slot is occupied and not accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_valid <= 1'b0;
      r_is_pf <= 1'b0;
      r_req   <= '0;
    end else if (w_free) begin
      if (w_gnt_dm) begin
        r_state <= ST_DM;
        r_valid <= 1'b1;
        r_is_pf <= 1'b0;
        r_req   <= dm_ar.req;
      end else if (w_gnt_pf) begin
        r_state <= ST_PF;
        r_valid <= 1'b1;
        r_is_pf <= 1'b1;
        r_req   <= pf_ar.req;
      end else begin
        r_state <= ST_EMPTY;
        r_valid <= 1'b0;
        r_is_pf <= 1'b0;
      end
    end
  end

  // In-flight prefetch bursts: count at grant, release on pf_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
      r_err <= 1'b0;
    end else begin
      if (pf_done & (r_out == '0)) begin
        r_err <= 1'b1;
      end
      case ({w_gnt_pf, w_done_ok})
        2'b10:   r_out <= r_out + OUTS_W'(1);
        2'b01:   r_out <= r_out - OUTS_W'(1);
        default: r_out <= r_out;
      endcase
    end
  end

endmodule
